// File: rtl/alu_mul_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_mul_sequencer_pkg                                  |
// | Description : Shared ALUCtrl opcode constants and the multiply       |
// |               sequencer state encoding.                              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package alu_mul_sequencer_pkg;

  // ALUCtrl codes driven by ALU_Ctrl into the EX stage.
  localparam logic [3:0] c_OP_AND  = 4'b0000;
  localparam logic [3:0] c_OP_OR   = 4'b0001;
  localparam logic [3:0] c_OP_ADD  = 4'b0010;
  localparam logic [3:0] c_OP_SUB  = 4'b0110;
  localparam logic [3:0] c_OP_SLT  = 4'b0111;
  localparam logic [3:0] c_OP_MUL  = 4'b1001;
  localparam logic [3:0] c_OP_NOR  = 4'b1100;
  localparam logic [3:0] c_OP_JUMP = 4'b1111;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage : alu_mul_sequencer_pkg
`default_nettype wire

// File: rtl/alu_mul_sequencer_dp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mul_shift_add_dp                                       |
// | Description : Shift-add multiplier datapath. One partial product is  |
// |               accumulated per step; the product is truncated to      |
// |               WIDTH bits.                                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
// | Ports                                                                |
// |   clk_i       in   1      clock                                      |
// |   rst_i       in   1      synchronous active-high reset              |
// |   i_load      in   1      latch operands, clear acc and count        |
// |   i_step      in   1      perform one shift-add iteration            |
// |   i_src1      in   WIDTH  multiplicand                                |
// |   i_src2      in   WIDTH  multiplier                                  |
// |   o_acc_next  out  WIDTH  accumulator value after the current step   |
// |   o_last_iter out  1      current step is the final (WIDTH-th) one   |
// +----------------------------------------------------------------------+
module mul_shift_add_dp #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_src1,
  input  logic [WIDTH-1:0] i_src2,
  output logic [WIDTH-1:0] o_acc_next,
  output logic             o_last_iter
);

  localparam int              CNT_W  = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] w_acc_next;

  // Exposed so the sequencer can capture the final product on the same
  // edge that completes the last iteration.
  assign w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign o_acc_next  = w_acc_next;
  assign o_last_iter = (r_count == c_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= i_src1;
      r_mplier <= i_src2;
      r_count  <= '0;
    end else if (i_step) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + CNT_W'(1);
    end
  end

endmodule : mul_shift_add_dp
`default_nettype wire

// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_mul_sequencer                                      |
// | Description : EX-stage multi-cycle multiply sequencer. Decodes the   |
// |               multiply ALUCtrl code, stalls the pipeline for WIDTH+1 |
// |               cycles and presents the product for one cycle.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
// | Ports                                                                |
// |   clk_i          in   1      clock                                   |
// |   rst_i          in   1      synchronous active-high reset           |
// |   valid_i        in   1      EX holds a valid instruction            |
// |   alu_ctrl_i     in   4      ALUCtrl code                            |
// |   flush_i        in   1      EX flush; aborts any multiply           |
// |   src1_i         in   WIDTH  multiplicand                            |
// |   src2_i         in   WIDTH  multiplier                              |
// |   stall_o        out  1      hold PC and IF/ID/EX registers          |
// |   busy_o         out  1      sequencer not idle                      |
// |   result_valid_o out  1      one-cycle pulse with a new product      |
// |   result_o       out  WIDTH  last completed product                  |
// +----------------------------------------------------------------------+
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] MUL_CODE = c_OP_MUL
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [3:0]       alu_ctrl_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             result_valid_o,
  output logic [WIDTH-1:0] result_o
);

  mul_state_e       r_state;
  mul_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_result;
  logic             w_req;
  logic             w_load;
  logic             w_step;
  logic             w_capture;
  logic             w_stall;
  logic             w_result_valid;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last_iter;

  assign w_req = valid_i & (alu_ctrl_i == MUL_CODE);

  mul_shift_add_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_src1      (src1_i),
    .i_src2      (src2_i),
    .o_acc_next  (w_acc_next),
    .o_last_iter (w_last_iter)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_result <= w_acc_next;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_load         = 1'b0;
    w_step         = 1'b0;
    w_capture      = 1'b0;
    w_stall        = 1'b0;
    w_result_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req && !flush_i) begin
          w_load      = 1'b1;
          w_stall     = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (flush_i) begin
          w_state_nxt = IDLE;
        end else begin
          w_step  = 1'b1;
          w_stall = 1'b1;
          // Fixed latency: exit only after the WIDTH-th iteration, even if
          // the remaining multiplier bits are all zero.
          if (w_last_iter) begin
            w_capture   = 1'b1;
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        // The stalled MUL still sits in EX here; it must not restart.
        w_result_valid = !flush_i;
        w_state_nxt    = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Reset masks the combinational outputs so a request present during
  // reset never raises stall.
  assign stall_o        = w_stall & !rst_i;
  assign busy_o         = (r_state != IDLE) & !rst_i;
  assign result_valid_o = w_result_valid & !rst_i;
  assign result_o       = r_result;

endmodule : alu_mul_sequencer
`default_nettype wire
